// File: rtl/game_timer_if.sv
// rtl/game_timer_if.sv - control/status bundle between the game-state logic and the game timer
interface game_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Load;
  logic [WIDTH-1:0] Load_val;
  logic             Load_up;
  logic             Start;
  logic             Stop;
  logic             Add;
  logic [WIDTH-1:0] Add_val;
  logic             tick;
  logic [WIDTH-1:0] counter_out;
  logic             expired;
  logic             running;
  logic             done;

  // game-state side: issues commands, observes the timer
  modport master (
    output Load, Load_val, Load_up, Start, Stop, Add, Add_val,
    input  tick, counter_out, expired, running, done
  );

  // timer side
  modport slave (
    input  Load, Load_val, Load_up, Start, Stop, Add, Add_val,
    output tick, counter_out, expired, running, done
  );
endinterface

// File: rtl/game_timer.sv
// rtl/game_timer.sv - prescaled up/down game timer with pause, bonus add and expiry pulse
module game_timer #(
  parameter int unsigned      CLK_HZ   = 50_000_000,
  parameter int unsigned      TICK_HZ  = 1,
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  game_timer_if.slave  bus
);
  localparam int unsigned      DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned      PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_TOP = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] counter, counter_n;
  logic             mode_up, mode_up_n;
  logic [PW-1:0]    presc, presc_n;
  logic             tick_r, tick_n;
  logic             expired_r, expired_n;
  logic             running_r, done_r;

  logic [WIDTH-1:0] add_amt;
  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] sum_sat;
  logic [WIDTH-1:0] term_val;
  logic             presc_due;

  // bonus time saturates at all-ones; up mode never adds
  always_comb begin
    add_amt  = (bus.Add && !mode_up) ? bus.Add_val : '0;
    sum_wide = {1'b0, counter} + {1'b0, add_amt};
    sum_sat  = sum_wide[WIDTH] ? ALL_ONES : sum_wide[WIDTH-1:0];
    term_val = mode_up ? ALL_ONES : '0;
    presc_due = (presc == '0);
  end

  // next-state, counter and prescaler decisions; Load overrides everything
  always_comb begin
    state_n   = state;
    counter_n = counter;
    mode_up_n = mode_up;
    presc_n   = presc;
    tick_n    = 1'b0;
    expired_n = 1'b0;
    if (bus.Load) begin
      counter_n = bus.Load_val;
      mode_up_n = bus.Load_up;
      presc_n   = PRESC_TOP;
      state_n   = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_PAUSE: begin
          counter_n = sum_sat;
          if (bus.Start) begin
            // starting on a terminal value expires at once without a tick
            if (sum_sat == term_val) begin
              state_n   = S_DONE;
              expired_n = 1'b1;
            end else begin
              state_n = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.Stop) begin
            // the Stop cycle still counts toward the period, but a due tick is deferred to resume
            counter_n = sum_sat;
            state_n   = S_PAUSE;
            if (!presc_due) presc_n = presc - 1'b1;
          end else if (presc_due) begin
            presc_n   = PRESC_TOP;
            tick_n    = 1'b1;
            counter_n = mode_up ? counter + 1'b1 : sum_sat - 1'b1;
            if (counter_n == term_val) begin
              state_n   = S_DONE;
              expired_n = 1'b1;
            end
          end else begin
            presc_n   = presc - 1'b1;
            counter_n = sum_sat;
          end
        end
        S_DONE: begin
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // state and datapath registers; all outputs are registered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      counter   <= INIT_VAL;
      mode_up   <= 1'b0;
      presc     <= PRESC_TOP;
      tick_r    <= 1'b0;
      expired_r <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      mode_up   <= mode_up_n;
      presc     <= presc_n;
      tick_r    <= tick_n;
      expired_r <= expired_n;
      running_r <= (state_n == S_RUN);
      done_r    <= (state_n == S_DONE);
    end
  end

  assign bus.tick        = tick_r;
  assign bus.counter_out = counter;
  assign bus.expired     = expired_r;
  assign bus.running     = running_r;
  assign bus.done        = done_r;
endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - self-checking bench for game_timer with a behavioural reference model
module tb_game_timer;
  localparam int W    = 4;
  localparam int DIV  = 10;
  localparam int MAXV = 15;
  localparam int INIT = 7;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  game_timer_if #(.WIDTH(W)) bus ();

  game_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .WIDTH(W), .INIT_VAL(4'd7)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  int compared = 0;
  int mismatched = 0;
  int n_ticks = 0;
  bit prev_exp = 1'b0;

  int m_cnt, m_ph, m_st;
  bit m_up, m_tick, m_exp;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: m_ph counts RUN edges elapsed in the current tick period
  always @(posedge Clk or negedge Reset) begin : ref_model
    int c, ph, st, addv, s;
    bit up, tk, ex, due;
    if (!Reset) begin
      m_cnt <= INIT; m_up <= 1'b0; m_ph <= 0; m_st <= ST_IDLE;
      m_tick <= 1'b0; m_exp <= 1'b0;
    end else begin
      c = m_cnt; ph = m_ph; st = m_st; up = m_up; tk = 1'b0; ex = 1'b0;
      addv = (bus.Add && !up) ? int'(bus.Add_val) : 0;
      s = (c + addv > MAXV) ? MAXV : c + addv;
      if (bus.Load) begin
        c = int'(bus.Load_val); up = bus.Load_up; st = ST_IDLE; ph = 0;
      end else if (st == ST_IDLE || st == ST_PAUSE) begin
        c = s;
        if (bus.Start) begin
          if (c == (up ? MAXV : 0)) begin st = ST_DONE; ex = 1'b1; end
          else st = ST_RUN;
        end
      end else if (st == ST_RUN) begin
        due = (ph == DIV - 1);
        if (bus.Stop) begin
          c = s; st = ST_PAUSE;
          if (!due) ph++;
        end else if (due) begin
          ph = 0; tk = 1'b1;
          c = up ? c + 1 : s - 1;
          if (c == (up ? MAXV : 0)) begin st = ST_DONE; ex = 1'b1; end
        end else begin
          ph++; c = s;
        end
      end
      m_cnt <= c; m_ph <= ph; m_st <= st; m_up <= up; m_tick <= tk; m_exp <= ex;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge Clk) begin
    chk("tick", int'(bus.tick), int'(m_tick));
    chk("counter_out", int'(bus.counter_out), m_cnt);
    chk("expired", int'(bus.expired), int'(m_exp));
    chk("running", int'(bus.running), int'(m_st == ST_RUN));
    chk("done", int'(bus.done), int'(m_st == ST_DONE));
    if (prev_exp && bus.expired) chk("expired_twice", 1, 0);
    prev_exp <= bus.expired;
    if (bus.tick) n_ticks <= n_ticks + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic load(input int v, input bit up);
    bus.Load = 1'b1; bus.Load_val = W'(v); bus.Load_up = up;
    step(1);
    bus.Load = 1'b0;
  endtask

  task automatic pulse_start;
    bus.Start = 1'b1; step(1); bus.Start = 1'b0;
  endtask

  task automatic pulse_stop;
    bus.Stop = 1'b1; step(1); bus.Stop = 1'b0;
  endtask

  task automatic pulse_add(input int v);
    bus.Add = 1'b1; bus.Add_val = W'(v); step(1); bus.Add = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    bus.Load = 1'b0; bus.Load_val = '0; bus.Load_up = 1'b0;
    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Add = 1'b0; bus.Add_val = '0;
    step(2);
    chk("rst_counter", int'(bus.counter_out), 7);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_tick", int'(bus.tick), 0);
    Reset = 1'b1;
    step(1);

    // countdown from 3 to expiry
    load(3, 1'b0);
    pulse_start;
    step(9);
    chk("t1_no_early_tick", int'(bus.tick), 0);
    step(1);
    chk("t1_tick1", int'(bus.tick), 1);
    chk("t1_cnt2", int'(bus.counter_out), 2);
    step(10);
    chk("t1_cnt1", int'(bus.counter_out), 1);
    step(10);
    chk("t1_cnt0", int'(bus.counter_out), 0);
    chk("t1_expired", int'(bus.expired), 1);
    chk("t1_done", int'(bus.done), 1);
    step(1);
    nt = n_ticks;
    step(50);
    chk("t1_no_more_ticks", n_ticks, nt);

    // pause keeps the partial period
    load(5, 1'b0);
    pulse_start;
    step(14);
    pulse_stop;
    chk("t2_paused", int'(bus.running), 0);
    chk("t2_cnt4", int'(bus.counter_out), 4);
    step(6);
    pulse_start;
    step(4);
    chk("t2_no_tick_t26", int'(bus.tick), 0);
    step(1);
    chk("t2_tick_t27", int'(bus.tick), 1);
    chk("t2_cnt3", int'(bus.counter_out), 3);

    // bonus on the tick that would have expired
    load(2, 1'b0);
    pulse_start;
    step(10);
    chk("t3_cnt1", int'(bus.counter_out), 1);
    step(9);
    bus.Add = 1'b1; bus.Add_val = 4'd5;
    step(1);
    bus.Add = 1'b0;
    chk("t3_cnt5", int'(bus.counter_out), 5);
    chk("t3_no_expire", int'(bus.expired), 0);
    chk("t3_running", int'(bus.running), 1);

    // Stop on the tick edge defers the tick to the first RUN cycle after resume
    load(3, 1'b0);
    pulse_start;
    step(9);
    pulse_stop;
    chk("ts_no_tick", int'(bus.tick), 0);
    chk("ts_cnt3", int'(bus.counter_out), 3);
    step(1);
    pulse_start;
    step(1);
    chk("ts_tick_resume", int'(bus.tick), 1);
    chk("ts_cnt2", int'(bus.counter_out), 2);

    // Load on a tick edge discards the update
    step(9);
    load(9, 1'b0);
    chk("tl_no_tick", int'(bus.tick), 0);
    chk("tl_cnt9", int'(bus.counter_out), 9);

    // saturation and up mode
    load(14, 1'b0);
    pulse_add(5);
    chk("t4_sat15", int'(bus.counter_out), 15);
    load(13, 1'b1);
    pulse_start;
    step(10);
    chk("t4_cnt14", int'(bus.counter_out), 14);
    chk("t4_not_done", int'(bus.done), 0);
    step(10);
    chk("t4_cnt15", int'(bus.counter_out), 15);
    chk("t4_expired", int'(bus.expired), 1);
    chk("t4_done", int'(bus.done), 1);

    // asynchronous reset mid-RUN
    load(9, 1'b0);
    pulse_start;
    step(10);
    #2 Reset = 1'b0;
    #1;
    chk("t5_cnt_init", int'(bus.counter_out), 7);
    chk("t5_tick0", int'(bus.tick), 0);
    chk("t5_running0", int'(bus.running), 0);
    step(1);
    Reset = 1'b1;
    step(1);
    nt = n_ticks;
    step(30);
    chk("t5_no_ticks", n_ticks, nt);
    chk("t5_cnt_hold", int'(bus.counter_out), 7);

    // start on terminal value
    nt = n_ticks;
    load(0, 1'b0);
    pulse_start;
    chk("t6_expired", int'(bus.expired), 1);
    chk("t6_done", int'(bus.done), 1);
    chk("t6_tick0", int'(bus.tick), 0);
    step(1);
    chk("t6_exp_once", int'(bus.expired), 0);
    pulse_start;
    pulse_add(4);
    chk("t6_add_ignored", int'(bus.counter_out), 0);
    chk("t6_still_done", int'(bus.done), 1);
    load(2, 1'b0);
    chk("t6_load_done0", int'(bus.done), 0);
    chk("t6_load_cnt2", int'(bus.counter_out), 2);
    step(1);
    chk("t6_never_ticked", n_ticks, nt);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
